counter_n: RTL

Parametrised successor to the 16-bit program counter: a WIDTH-bit up/down counter with load, synchronous clear, programmable step and programmable upper limit. It supports wrap or saturate behaviour at both ends and provides terminal flags plus a one-cycle wrap pulse. It serves as the program counter in wider CPU variants and as the generic loop/address counter in peripherals.

---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_next.sv | 63 ++++++
 rtl/counter_n.sv | 62 ++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - end-mode constants and width helper for counter_n
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Internal arithmetic carries one extra bit so out+step never overflows.
  function automatic int sum_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/counter_next.sv
// rtl/counter_next.sv - combinational next count and wrap flag for counter_n
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4,
  parameter int MODE   = CNT_WRAP
) (
  input  logic [WIDTH-1:0]  cur,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              up,
  output logic [WIDTH-1:0]  nxt,
  output logic              wrapped
);

  localparam int SW = sum_w(WIDTH);

  logic [SW-1:0] cur_x;
  logic [SW-1:0] step_x;
  logic [SW-1:0] lim_x;
  logic [SW-1:0] span;
  logic [SW-1:0] sum;

  assign cur_x  = SW'(cur);
  assign step_x = SW'(step);
  assign lim_x  = SW'(limit);
  assign span   = lim_x + SW'(1);
  assign sum    = cur_x + step_x;

  always_comb begin
    nxt     = cur;
    wrapped = 1'b0;
    if (cur_x > lim_x) begin
      // Only reachable after a load above limit.
      if (up && MODE == CNT_WRAP) begin
        nxt     = '0;
        wrapped = 1'b1;
      end else begin
        nxt     = limit;
      end
    end else if (up) begin
      if (sum <= lim_x) begin
        nxt = WIDTH'(sum);
      end else if (MODE == CNT_WRAP) begin
        nxt     = WIDTH'(sum - span);
        wrapped = 1'b1;
      end else begin
        nxt = limit;
      end
    end else begin
      if (cur_x >= step_x) begin
        nxt = WIDTH'(cur_x - step_x);
      end else if (MODE == CNT_WRAP) begin
        nxt     = WIDTH'(cur_x + span - step_x);
        wrapped = 1'b1;
      end else begin
        nxt = '0;
      end
    end
  end

endmodule

// File: rtl/counter_n.sv
// rtl/counter_n.sv - parametrised up/down counter with load, clear, step and limit
module counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4,
  parameter int MODE   = CNT_WRAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic              clear,
  input  logic              inc,
  input  logic              dec,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  out,
  output logic              at_max,
  output logic              at_zero,
  output logic              wrap
);

  logic [WIDTH-1:0] nxt;
  logic             nxt_wrap;

  counter_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W),
    .MODE   (MODE)
  ) u_next (
    .cur     (out),
    .step    (step),
    .limit   (limit),
    .up      (inc),
    .nxt     (nxt),
    .wrapped (nxt_wrap)
  );

  // clear > load > (inc xor dec) > hold; wrap only ever follows a counting update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out  <= '0;
      wrap <= 1'b0;
    end else if (clear) begin
      out  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      out  <= in;
      wrap <= 1'b0;
    end else if (inc ^ dec) begin
      out  <= nxt;
      wrap <= nxt_wrap;
    end else begin
      wrap <= 1'b0;
    end
  end

  assign at_max  = (out >= limit);
  assign at_zero = (out == '0);

endmodule
